// File: rtl/grating_motion_ctrl.sv
// Purpose     : command-driven quadrature encoder emulator; counted, reversible, abortable moves timed by an NCO.
// Latency     : first edge ceil(2^ACC_W/inc) clocks after RUN entry; done one clock after the final step/abort.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid outside IDLE is dropped, not queued.
//
// Ports:
//   CLOCK_50M, RST_n            clock and asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (accept when both high)
//   cmd_dir, cmd_count, cmd_inc direction (0 = A leads B), edge count, NCO increment
//   abort                       terminate a running move
//   busy, done, done_aborted    status; done is a one-cycle pulse, done_aborted qualifies it
//   enc_a, enc_b, enc_z         encoder-style quadrature and index outputs
//   position                    signed edge count since reset (wraps)
module grating_motion_ctrl #(
    parameter int ACC_W         = 32,
    parameter int POS_W         = 32,
    parameter int LINES_PER_REV = 2500
) (
    input  logic             CLOCK_50M,
    input  logic             RST_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [31:0]      cmd_count,
    input  logic [ACC_W-1:0] cmd_inc,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             done_aborted,
    output logic             enc_a,
    output logic             enc_b,
    output logic             enc_z,
    output logic [POS_W-1:0] position
);

    localparam int REV_EDGES = 4 * LINES_PER_REV;
    localparam int REV_W     = (REV_EDGES > 2) ? $clog2(REV_EDGES) : 1;
    localparam logic [REV_W-1:0] REV_LAST = REV_W'(REV_EDGES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_inc;
    logic               r_dir;
    logic [31:0]        r_remaining;
    logic [1:0]         r_phase;
    logic [REV_W-1:0]   r_rev_idx;
    logic [POS_W-1:0]   r_position;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_done_aborted;
    logic               r_enc_a;
    logic               r_enc_b;
    logic               r_enc_z;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [ACC_W-1:0]   w_inc_nxt;
    logic               w_dir_nxt;
    logic [31:0]        w_rem_nxt;
    logic               w_step;
    logic               w_aborted_nxt;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic               w_last;
    logic [1:0]         w_phase_nxt;
    logic [REV_W-1:0]   w_rev_nxt;
    logic [POS_W-1:0]   w_pos_nxt;
    logic               w_enc_a_nxt;
    logic               w_enc_b_nxt;
    logic               w_enc_z_nxt;

    // NCO: the carry out of the accumulator add is the step strobe on the same edge.
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry = w_sum[ACC_W];
    assign w_last  = (r_remaining == 32'd1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, command latching, step decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_inc_nxt     = r_inc;
        w_dir_nxt     = r_dir;
        w_rem_nxt     = r_remaining;
        w_step        = 1'b0;
        w_aborted_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_acc_nxt = '0;
                    // A zero increment would never produce a carry; run at the slowest rate instead.
                    w_inc_nxt = (cmd_inc == '0) ? ACC_W'(1) : cmd_inc;
                    w_dir_nxt = cmd_dir;
                    w_rem_nxt = cmd_count;
                    // A zero-length move skips RUN so no edge can ever be emitted.
                    w_state_nxt = (cmd_count == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_acc_nxt = w_sum[ACC_W-1:0];
                // Abort suppresses a pending step, except the final one: a move that
                // completes on the abort cycle is reported as a normal completion.
                if (w_carry && (w_last || !abort)) begin
                    w_step    = 1'b1;
                    w_rem_nxt = r_remaining - 32'd1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end else if (abort) begin
                    w_state_nxt   = S_DONE;
                    w_aborted_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Step datapath: phase, revolution index, position, encoder pins
    // ------------------------------------------------------------------
    always_comb begin
        w_phase_nxt = r_phase;
        w_rev_nxt   = r_rev_idx;
        w_pos_nxt   = r_position;

        if (w_step) begin
            if (r_dir) begin
                w_phase_nxt = r_phase - 2'd1;
                w_rev_nxt   = (r_rev_idx == '0) ? REV_LAST : (r_rev_idx - REV_W'(1));
                w_pos_nxt   = r_position - POS_W'(1);
            end else begin
                w_phase_nxt = r_phase + 2'd1;
                w_rev_nxt   = (r_rev_idx == REV_LAST) ? '0 : (r_rev_idx + REV_W'(1));
                w_pos_nxt   = r_position + POS_W'(1);
            end
        end

        // Gray sequence 00 -> 10 -> 11 -> 01: only one pin toggles per step.
        w_enc_a_nxt = (w_phase_nxt == 2'd1) || (w_phase_nxt == 2'd2);
        w_enc_b_nxt = (w_phase_nxt == 2'd2) || (w_phase_nxt == 2'd3);
        w_enc_z_nxt = (w_rev_nxt == '0);
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            r_acc          <= '0;
            r_inc          <= '0;
            r_dir          <= 1'b0;
            r_remaining    <= '0;
            r_phase        <= 2'd0;
            r_rev_idx      <= '0;
            r_position     <= '0;
            r_cmd_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_done_aborted <= 1'b0;
            r_enc_a        <= 1'b0;
            r_enc_b        <= 1'b0;
            r_enc_z        <= 1'b1;
        end else begin
            r_acc          <= w_acc_nxt;
            r_inc          <= w_inc_nxt;
            r_dir          <= w_dir_nxt;
            r_remaining    <= w_rem_nxt;
            r_phase        <= w_phase_nxt;
            r_rev_idx      <= w_rev_nxt;
            r_position     <= w_pos_nxt;
            // Status flags are registered copies of the decoded next state.
            r_cmd_ready    <= (w_state_nxt == S_IDLE);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done         <= (w_state_nxt == S_DONE);
            r_done_aborted <= w_aborted_nxt;
            r_enc_a        <= w_enc_a_nxt;
            r_enc_b        <= w_enc_b_nxt;
            r_enc_z        <= w_enc_z_nxt;
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign done_aborted = r_done_aborted;
    assign enc_a        = r_enc_a;
    assign enc_b        = r_enc_b;
    assign enc_z        = r_enc_z;
    assign position     = r_position;

endmodule

// File: tb/tb_grating_motion_ctrl.sv
// Purpose     : directed self-checking bench for grating_motion_ctrl (8-bit NCO, 4 lines/rev).
// Latency     : inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Backpressure: commands are only issued while the DUT is idle, except the ignored-command case.
module tb_grating_motion_ctrl;

    localparam int ACC_W = 8;
    localparam int POS_W = 32;
    localparam int LP    = 4;

    logic             CLOCK_50M;
    logic             RST_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [31:0]      cmd_count;
    logic [ACC_W-1:0] cmd_inc;
    logic             abort;
    logic             busy;
    logic             done;
    logic             done_aborted;
    logic             enc_a;
    logic             enc_b;
    logic             enc_z;
    logic [POS_W-1:0] position;

    int n_checks;
    int n_errors;

    grating_motion_ctrl #(
        .ACC_W         (ACC_W),
        .POS_W         (POS_W),
        .LINES_PER_REV (LP)
    ) u_dut (
        .CLOCK_50M    (CLOCK_50M),
        .RST_n        (RST_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_count    (cmd_count),
        .cmd_inc      (cmd_inc),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .done_aborted (done_aborted),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .enc_z        (enc_z),
        .position     (position)
    );

    initial begin
        CLOCK_50M = 1'b0;
        forever #10 CLOCK_50M = ~CLOCK_50M;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50M);
        #1;
    endtask

    // One-cycle command; returns 1 time unit after the accepting edge.
    task automatic send_cmd(input logic dir, input logic [31:0] cnt, input logic [ACC_W-1:0] inc);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = cnt;
        cmd_inc   = inc;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Counts edges until done is seen; an expired budget is a failed check.
    task automatic wait_done(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < max_cyc);
        if (!done) chk("done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int n;
        logic [1:0] ab_fwd [4];
        logic [1:0] ab_rev [4];
        ab_fwd[0] = 2'b10; ab_fwd[1] = 2'b11; ab_fwd[2] = 2'b01; ab_fwd[3] = 2'b00;
        ab_rev[0] = 2'b01; ab_rev[1] = 2'b11; ab_rev[2] = 2'b10; ab_rev[3] = 2'b00;

        n_checks  = 0;
        n_errors  = 0;
        RST_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        cmd_inc   = '0;
        abort     = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_done",  done, 1'b0);
        chk("rst_abt",   done_aborted, 1'b0);
        chk("rst_ab",    {enc_a, enc_b}, 2'b00);
        chk("rst_z",     enc_z, 1'b1);
        chk("rst_pos",   position, 0);
        RST_n = 1'b1;
        tick();

        // Abort while idle is ignored
        abort = 1'b1;
        tick();
        chk("idle_abort_busy", busy, 1'b0);
        chk("idle_abort_done", done, 1'b0);
        abort = 1'b0;

        // 1: forward, 8 edges, one edge every 2 clocks
        send_cmd(1'b0, 32'd8, 8'd128);
        chk("fwd_ready_low", cmd_ready, 1'b0);
        chk("fwd_busy",      busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fwd_hold_ab", {enc_a, enc_b}, (i == 0) ? 2'b00 : ab_fwd[(i + 3) % 4]);
            tick();
            chk("fwd_ab", {enc_a, enc_b}, ab_fwd[i % 4]);
        end
        chk("fwd_done",     done, 1'b1);
        chk("fwd_done_abt", done_aborted, 1'b0);
        chk("fwd_pos",      position, 8);
        tick();
        chk("fwd_done_once", done, 1'b0);
        chk("fwd_idle_rdy",  cmd_ready, 1'b1);

        // 2: reverse, 8 edges, B leads A
        send_cmd(1'b1, 32'd8, 8'd128);
        for (int i = 0; i < 8; i++) begin
            tick();
            tick();
            chk("rev_ab", {enc_a, enc_b}, ab_rev[i % 4]);
        end
        chk("rev_done",     done, 1'b1);
        chk("rev_done_abt", done_aborted, 1'b0);
        chk("rev_pos",      position, 0);
        chk("rev_z",        enc_z, 1'b1);
        tick();

        // 3: zero-length move, done at T+1
        send_cmd(1'b0, 32'd0, 8'd128);
        chk("zero_done",  done, 1'b1);
        chk("zero_busy",  busy, 1'b1);
        chk("zero_rdy",   cmd_ready, 1'b0);
        chk("zero_ab",    {enc_a, enc_b}, 2'b00);
        chk("zero_pos",   position, 0);
        tick();
        chk("zero_done_clr", done, 1'b0);
        chk("zero_rdy_back", cmd_ready, 1'b1);

        // 4: abort after 20 clocks at one edge per 4 clocks -> 5 edges
        send_cmd(1'b0, 32'd100, 8'd64);
        repeat (20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", done, 1'b1);
        chk("abort_flag", done_aborted, 1'b1);
        chk("abort_pos",  position, 5);
        chk("abort_ab",   {enc_a, enc_b}, 2'b10);
        chk("abort_z",    enc_z, 1'b0);
        tick();
        chk("abort_rdy",  cmd_ready, 1'b1);
        chk("abort_hold", position, 5);

        // Asynchronous reset in the middle of a move
        send_cmd(1'b0, 32'd100, 8'd128);
        repeat (7) tick();
        chk("mid_pos", position, 8);
        RST_n = 1'b0;
        #1;
        chk("arst_pos",  position, 0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rdy",  cmd_ready, 1'b1);
        chk("arst_ab",   {enc_a, enc_b}, 2'b00);
        chk("arst_z",    enc_z, 1'b1);
        tick();
        RST_n = 1'b1;
        repeat (4) tick();
        chk("arst_stays_idle", position, 0);

        // 5: index pulse over two revolutions (16 edges per rev)
        chk("z_start", enc_z, 1'b1);
        send_cmd(1'b0, 32'd32, 8'd128);
        for (int k = 1; k <= 32; k++) begin
            tick();
            tick();
            chk("z_fwd", enc_z, (k % 16) == 0);
        end
        chk("z_fwd_pos", position, 32);
        tick();
        send_cmd(1'b1, 32'd1, 8'd128);
        wait_done(10, n);
        chk("z_rev_z",   enc_z, 1'b0);
        chk("z_rev_pos", position, 31);
        chk("z_rev_ab",  {enc_a, enc_b}, 2'b01);
        tick();
        send_cmd(1'b0, 32'd1, 8'd128);
        wait_done(10, n);
        chk("z_wrap_z",   enc_z, 1'b1);
        chk("z_wrap_pos", position, 32);
        tick();

        // 6a: cmd_valid held through RUN with different fields is ignored
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_count = 32'd2;
        cmd_inc   = 8'd128;
        tick();
        cmd_dir   = 1'b1;
        cmd_count = 32'd50;
        cmd_inc   = 8'd1;
        wait_done(20, n);
        cmd_valid = 1'b0;
        chk("held_cycles", n, 4);
        chk("held_pos",    position, 34);
        tick();
        chk("held_idle_busy", busy, 1'b0);
        chk("held_idle_pos",  position, 34);

        // 6b: zero increment runs at increment 1 -> first edge after 2^ACC_W clocks
        send_cmd(1'b0, 32'd1, 8'd0);
        wait_done(400, n);
        chk("inc0_cycles", n, 256);
        chk("inc0_pos",    position, 35);
        chk("inc0_ab",     {enc_a, enc_b}, 2'b01);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
